trivium_stream_xor: RTL and testbench

- Streaming cipher datapath for the Trivium keystream generator: loads an 80-bit key and IV, runs the 1152-round warm-up, then XORs W keystream bits per accepted data word.
- Encryption and decryption are the same XOR; this block is the receive-side decryptor that recovers plaintext from a ciphertext word stream.
- Sits between the ciphertext source (valid/ready) and the plaintext sink (valid/ready).

---
 rtl/trivium_pkg.sv | 46 ++++
 rtl/trivium_stream_xor_round_w.sv | 36 +++
 rtl/trivium_stream_xor.sv | 98 +++++++++
 tb/tb_trivium_stream_xor.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared Trivium constants, FSM state type and key/IV load helpers.
package trivium_pkg;

    localparam int unsigned KEY_W       = 80;
    localparam int unsigned IV_W        = 80;
    localparam int unsigned STATE_W     = 288;
    localparam int unsigned INIT_ROUNDS = 1152;

    // Tap positions into SET[287:0]: XOR pair, AND pair, feedback bit per register
    localparam int unsigned T1_A = 65;
    localparam int unsigned T1_B = 92;
    localparam int unsigned T1_C = 90;
    localparam int unsigned T1_D = 91;
    localparam int unsigned T1_E = 170;
    localparam int unsigned T2_A = 161;
    localparam int unsigned T2_B = 176;
    localparam int unsigned T2_C = 174;
    localparam int unsigned T2_D = 175;
    localparam int unsigned T2_E = 263;
    localparam int unsigned T3_A = 242;
    localparam int unsigned T3_B = 287;
    localparam int unsigned T3_C = 285;
    localparam int unsigned T3_D = 286;
    localparam int unsigned T3_E = 68;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic [KEY_W-1:0] byte_rev(input logic [KEY_W-1:0] x);
        logic [KEY_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < KEY_W / 8; i++) begin
            r[8*i +: 8] = x[KEY_W - 8 - 8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
        return {3'b111, 112'b0, byte_rev(iv), 13'b0, byte_rev(key)};
    endfunction

endpackage

// File: rtl/trivium_stream_xor_round_w.sv
// Combinational W-round unrolled Trivium update; first round's z lands in ks[W-1].
module trivium_round_w
    import trivium_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [STATE_W-1:0] set_in,
    output logic [STATE_W-1:0] set_out,
    output logic [W-1:0]       ks
);

    logic [STATE_W-1:0] s;
    logic               t1;
    logic               t2;
    logic               t3;

    always_comb begin
        s  = set_in;
        ks = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            t1 = s[T1_A] ^ s[T1_B];
            t2 = s[T2_A] ^ s[T2_B];
            t3 = s[T3_A] ^ s[T3_B];
            ks[W-1-i] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[T1_C] & s[T1_D]) ^ s[T1_E];
            t2 = t2 ^ (s[T2_C] & s[T2_D]) ^ s[T2_E];
            t3 = t3 ^ (s[T3_C] & s[T3_D]) ^ s[T3_E];
            s  = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
        end
        set_out = s;
    end

endmodule

// File: rtl/trivium_stream_xor.sv
// Trivium receive-side stream decryptor: key/IV load, 1152-round warm-up, Dout = Din ^ keystream.
// Define TRIVIUM_KSOBS_EN to expose the keystream word used for Dout on KSout.
module trivium_stream_xor
    import trivium_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [KEY_W-1:0] Kin,
    input  logic [IV_W-1:0]  IVin,
    input  logic             Krdy,
    output logic             Kvld,
    output logic             BSY,
    input  logic [W-1:0]     Din,
    input  logic             Drdy,
    output logic             Dacc,
    output logic [W-1:0]     Dout,
    output logic             Dvld,
    input  logic             Dack
`ifdef TRIVIUM_KSOBS_EN
    ,
    output logic [W-1:0]     KSout
`endif
);

    localparam int unsigned INIT_CYC = INIT_ROUNDS / W;
    localparam int unsigned CNT_W    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

    state_t             state;
    logic [STATE_W-1:0] set_q;
    logic [STATE_W-1:0] set_nxt;
    logic [W-1:0]       ks;
    logic [CNT_W-1:0]   cnt;

    trivium_round_w #(.W(W)) u_round (
        .set_in  (set_q),
        .set_out (set_nxt),
        .ks      (ks)
    );

    // Accept only with a free (or draining) output slot; a key reload wins over data
    assign Dacc = (state == RUN) & EN & Drdy & ~Krdy & (~Dvld | Dack);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            set_q <= '0;
            cnt   <= '0;
            Kvld  <= 1'b0;
            BSY   <= 1'b0;
            Dvld  <= 1'b0;
            Dout  <= '0;
`ifdef TRIVIUM_KSOBS_EN
            KSout <= '0;
`endif
        end else begin
            Kvld <= 1'b0;
            if (EN) begin
                if (Krdy) begin
                    state <= INIT;
                    set_q <= load_state(Kin, IVin);
                    cnt   <= '0;
                    BSY   <= 1'b1;
                    Dvld  <= 1'b0;
                end else begin
                    case (state)
                        INIT: begin
                            set_q <= set_nxt;
                            if (cnt == CNT_W'(INIT_CYC - 1)) begin
                                state <= RUN;
                                BSY   <= 1'b0;
                                Kvld  <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        RUN: begin
                            if (Dacc) begin
                                set_q <= set_nxt;
                                Dout  <= Din ^ ks;
                                Dvld  <= 1'b1;
`ifdef TRIVIUM_KSOBS_EN
                                KSout <= ks;
`endif
                            end else if (Dvld && Dack) begin
                                Dvld <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream_xor.sv
// Directed bench for trivium_stream_xor (W=8) against a bit-serial Trivium reference model.
module tb_trivium_stream_xor;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic [79:0] Kin;
    logic [79:0] IVin;
    logic        Krdy;
    logic        Kvld;
    logic        BSY;
    logic [7:0]  Din;
    logic        Drdy;
    logic        Dacc;
    logic [7:0]  Dout;
    logic        Dvld;
    logic        Dack;
`ifdef TRIVIUM_KSOBS_EN
    logic [7:0]  KSout;
`endif

    trivium_stream_xor #(.W(8)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .Kin  (Kin),
        .IVin (IVin),
        .Krdy (Krdy),
        .Kvld (Kvld),
        .BSY  (BSY),
        .Din  (Din),
        .Drdy (Drdy),
        .Dacc (Dacc),
        .Dout (Dout),
        .Dvld (Dvld),
        .Dack (Dack)
`ifdef TRIVIUM_KSOBS_EN
        ,
        .KSout(KSout)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [79:0] KEY0 = 80'h0;
    localparam logic [79:0] IV0  = 80'h0;
    localparam logic [79:0] KEY1 = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] IV1  = 80'hFEDCBA98765432100000;

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    bit         ms [1:288];
    logic [7:0] gbuf  [64];
    logic [7:0] gold0 [64];
    logic [7:0] gold1 [64];
    logic [7:0] pt    [64];
    logic [7:0] ex    [64];
    logic [7:0] got   [64];
    logic [7:0] orig  [64];
    vec_t       vecs  [16];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model in the textbook s1..s288 notation
    task automatic model_round(output bit z);
        bit t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
        ms[178] = t2;
    endtask

    task automatic gen_gold(input logic [79:0] k, input logic [79:0] iv);
        bit z;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[8*(9 - (i-1)/8) + (i-1)%8];
            ms[93 + i] = iv[8*(9 - (i-1)/8) + (i-1)%8];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        for (int r = 0; r < 1152; r++) model_round(z);
        for (int b = 0; b < 64; b++) begin
            for (int j = 7; j >= 0; j--) begin
                model_round(z);
                gbuf[b][j] = z;
            end
        end
    endtask

    // Entered at the negedge where Krdy was raised; counts BSY-high samples
    task automatic wait_warmup(input int exp_cyc, input int stall_at, input int stall_len);
        int cyc;
        @(negedge CLK);
        Krdy = 1'b0;
        Drdy = 1'b0;
        #1;
        check1("dvld_cleared_on_load", Dvld, 1'b0);
        cyc = 0;
        while (BSY === 1'b1 && cyc < 3000) begin
            cyc++;
            EN = !(stall_len != 0 && cyc > stall_at && cyc <= stall_at + stall_len);
            @(negedge CLK);
            #1;
        end
        EN = 1'b1;
        check_int("bsy_cycles", cyc, exp_cyc);
        check1("kvld_pulse", Kvld, 1'b1);
        @(negedge CLK);
        #1;
        check1("kvld_single", Kvld, 1'b0);
    endtask

    task automatic load_key(input logic [79:0] k, input logic [79:0] iv,
                            input int exp_cyc, input int stall_at, input int stall_len);
        @(negedge CLK);
        Kin  = k;
        IVin = iv;
        Krdy = 1'b1;
        wait_warmup(exp_cyc, stall_at, stall_len);
    endtask

    // Streams pt[0..n-1] with Dack held 1, checks Dout against ex[], records got[]
    task automatic run_stream(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            Drdy = 1'b1;
            Dack = 1'b1;
            Din  = pt[i];
            #1;
            check1("stream_dacc", Dacc, 1'b1);
            if (i > 0) begin
                check8("stream_dout", Dout, ex[i-1]);
                got[i-1] = Dout;
            end
        end
        @(negedge CLK);
        Drdy = 1'b0;
        #1;
        check8("stream_dout_last", Dout, ex[n-1]);
        check1("stream_dvld_last", Dvld, 1'b1);
        got[n-1] = Dout;
        @(negedge CLK);
        #1;
        check1("stream_dvld_drop", Dvld, 1'b0);
    endtask

    initial begin
        RST = 1'b1; EN = 1'b1; Kin = '0; IVin = '0; Krdy = 1'b0;
        Din = '0; Drdy = 1'b1; Dack = 1'b1;

        gen_gold(KEY0, IV0);
        for (int i = 0; i < 64; i++) gold0[i] = gbuf[i];
        gen_gold(KEY1, IV1);
        for (int i = 0; i < 64; i++) gold1[i] = gbuf[i];
        for (int i = 0; i < 16; i++) begin
            vecs[i].din  = 8'h00;
            vecs[i].dout = gold0[i];
        end

        // Reset state
        @(negedge CLK);
        #1;
        check1("rst_kvld", Kvld, 1'b0);
        check1("rst_bsy", BSY, 1'b0);
        check1("rst_dvld", Dvld, 1'b0);
        check8("rst_dout", Dout, 8'h00);
        check1("rst_dacc", Dacc, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check1("idle_dacc", Dacc, 1'b0);
        Drdy = 1'b0;

        // Zero key/IV warm-up and 16 keystream bytes from the vector table
        load_key(KEY0, IV0, 144, 0, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            Drdy = 1'b1;
            Din  = vecs[i].din;
            #1;
            check1("tbl_dacc", Dacc, 1'b1);
            if (i > 0) check8("tbl_dout", Dout, vecs[i-1].dout);
        end
        @(negedge CLK);
        Drdy = 1'b0;
        #1;
        check8("tbl_dout_last", Dout, vecs[15].dout);
        @(negedge CLK);

        // Backpressure: five stalled cycles, then no keystream skip or repeat
        Drdy = 1'b1; Din = 8'hA5; Dack = 1'b1;
        #1;
        check1("bp_first_acc", Dacc, 1'b1);
        @(negedge CLK);
        Din = 8'h3C; Dack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check1("bp_dacc_low", Dacc, 1'b0);
            check8("bp_dout_hold", Dout, 8'hA5 ^ gold0[16]);
            check1("bp_dvld_hold", Dvld, 1'b1);
            @(negedge CLK);
        end
        Dack = 1'b1;
        #1;
        check1("bp_resume_acc", Dacc, 1'b1);
        @(negedge CLK);
        Drdy = 1'b0;
        #1;
        check8("bp_next_word", Dout, 8'h3C ^ gold0[17]);

        // Krdy with Drdy in RUN: no accept, Dvld dropped, keystream restarts
        @(negedge CLK);
        Drdy = 1'b1; Din = 8'h5A;
        #1;
        check1("rl_pre_acc", Dacc, 1'b1);
        @(negedge CLK);
        Krdy = 1'b1; Din = 8'hFF;
        #1;
        check1("rl_krdy_blocks_dacc", Dacc, 1'b0);
        check8("rl_pre_dout", Dout, 8'h5A ^ gold0[18]);
        wait_warmup(144, 0, 0);
        for (int i = 0; i < 4; i++) begin
            pt[i] = 8'h00;
            ex[i] = gold0[i];
        end
        run_stream(4);

        // Round trip: encrypt 64 random bytes, reload, decrypt the ciphertext
        for (int i = 0; i < 64; i++) begin
            orig[i] = 8'($urandom);
            pt[i]   = orig[i];
            ex[i]   = orig[i] ^ gold1[i];
        end
        load_key(KEY1, IV1, 144, 0, 0);
        run_stream(64);
        for (int i = 0; i < 64; i++) begin
            pt[i] = got[i];
            ex[i] = orig[i];
        end
        load_key(KEY1, IV1, 144, 0, 0);
        run_stream(64);

        // Asynchronous reset 70 cycles into warm-up, then a clean reload
        @(negedge CLK);
        Kin = KEY1; IVin = IV1; Krdy = 1'b1;
        @(negedge CLK);
        Krdy = 1'b0;
        repeat (69) @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check1("mid_rst_bsy", BSY, 1'b0);
        check1("mid_rst_dvld", Dvld, 1'b0);
        check8("mid_rst_dout", Dout, 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        load_key(KEY1, IV1, 144, 0, 0);
        for (int i = 0; i < 8; i++) begin
            pt[i] = 8'($urandom);
            ex[i] = pt[i] ^ gold1[i];
        end
        run_stream(8);

        // EN low for 10 warm-up cycles stretches BSY by exactly 10
        load_key(KEY0, IV0, 154, 60, 10);
        for (int i = 0; i < 8; i++) begin
            pt[i] = 8'h00;
            ex[i] = gold0[i];
        end
        run_stream(8);

        // EN low in RUN freezes the output register even with Dack high
        @(negedge CLK);
        Drdy = 1'b1; Din = 8'h00; Dack = 1'b1;
        #1;
        check1("en_pre_acc", Dacc, 1'b1);
        @(negedge CLK);
        EN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check1("en_off_dacc", Dacc, 1'b0);
            check8("en_off_dout", Dout, gold0[8]);
            check1("en_off_dvld", Dvld, 1'b1);
            @(negedge CLK);
        end
        EN = 1'b1;
        #1;
        check1("en_on_acc", Dacc, 1'b1);
        @(negedge CLK);
        Drdy = 1'b0;
        #1;
        check8("en_on_next_word", Dout, gold0[9]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
